// File: rtl/connect4_pkg.sv
// Shared Connect-4 board geometry and cell/board types used by the move engine,
// move generators and win checker.
package connect4_pkg;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int CELLS = ROWS * COLS;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef cell_t board_t [0:ROWS-1][0:COLS-1];

endpackage

// File: rtl/piece_drop_engine.sv
// Accepts a column/player move, scans the column bottom-up one row per clock,
// drops the piece into the authoritative board register and reports where it landed.
module piece_drop_engine
  import connect4_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            move_valid,
  input  logic [2:0]      move_col,
  input  logic [1:0]      move_player,
  output logic            move_ready,
  output board_t          board,
  output logic [COLS-1:0] col_full,
  output logic            done,
  output logic [2:0]      placed_row,
  output logic [2:0]      placed_col,
  output logic            rejected,
  output logic [5:0]      move_count,
  output logic            board_full
);

  // Handshake: a move transfers on a rising edge where move_valid && move_ready;
  // column and player are captured on that edge and the inputs are ignored
  // until move_ready is high again.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_PLACE  = 2'd2,
    S_REJECT = 2'd3
  } state_t;

  localparam logic [2:0] ROW_LAST = 3'(ROWS - 1);
  localparam logic [2:0] COL_LAST = 3'(COLS - 1);
  localparam logic [5:0] CELLS_W  = 6'(CELLS);

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_col;
  cell_t      r_player;
  logic [2:0] r_scan_row;
  board_t     r_board;
  logic [5:0] r_count;
  logic [2:0] r_placed_row;
  logic [2:0] r_placed_col;

  logic w_handshake;
  logic w_legal;
  logic w_cell_empty;
  logic w_write;

  assign w_handshake  = move_valid && move_ready;
  assign w_legal      = (move_col <= COL_LAST) &&
                        ((move_player == 2'b01) || (move_player == 2'b10));
  assign w_cell_empty = (r_board[r_scan_row][r_col] == EMPTY);
  assign w_write      = (r_state == S_SCAN) && w_cell_empty;

  always_comb begin
    w_next_state = r_state;
    move_ready   = (r_state == S_IDLE) && !clear;
    done         = (r_state == S_PLACE);
    rejected     = (r_state == S_REJECT);
    case (r_state)
      S_IDLE: begin
        if (w_handshake) w_next_state = w_legal ? S_SCAN : S_REJECT;
      end
      S_SCAN: begin
        if (w_cell_empty)           w_next_state = S_PLACE;
        else if (r_scan_row == '0)  w_next_state = S_REJECT;
      end
      S_PLACE:  w_next_state = S_IDLE;
      S_REJECT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_player     <= EMPTY;
      r_scan_row   <= '0;
      r_count      <= '0;
      r_placed_row <= '0;
      r_placed_col <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_board[r][c] <= EMPTY;
    end else if (clear) begin
      // New game: wipe the board and drop any in-flight move silently.
      r_state <= S_IDLE;
      r_count <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_board[r][c] <= EMPTY;
    end else begin
      r_state <= w_next_state;
      if (w_handshake) begin
        r_col      <= move_col;
        r_player   <= cell_t'(move_player);
        r_scan_row <= ROW_LAST;
      end else if ((r_state == S_SCAN) && !w_cell_empty) begin
        r_scan_row <= r_scan_row - 3'd1;
      end
      if (w_write) begin
        r_board[r_scan_row][r_col] <= r_player;
        r_placed_row               <= r_scan_row;
        r_placed_col               <= r_col;
        r_count                    <= r_count + 6'd1;
      end
    end
  end

  // A column is full once its top cell is occupied.
  always_comb begin
    col_full = '0;
    for (int c = 0; c < COLS; c++)
      col_full[c] = (r_board[0][c] != EMPTY);
  end

  assign board      = r_board;
  assign placed_row = r_placed_row;
  assign placed_col = r_placed_col;
  assign move_count = r_count;
  assign board_full = (r_count == CELLS_W);

endmodule

// File: tb/tb_piece_drop_engine.sv
// Scoreboard bench for piece_drop_engine: drivers push expected done/rejected
// events (with landing cell, count and arrival cycle); a monitor pops and checks them.
module tb_piece_drop_engine;
  import connect4_pkg::*;

  localparam int W = 30;

  logic            clk;
  logic            rst;
  logic            clear;
  logic            move_valid;
  logic [2:0]      move_col;
  logic [1:0]      move_player;
  logic            move_ready;
  board_t          board;
  logic [COLS-1:0] col_full;
  logic            done;
  logic [2:0]      placed_row;
  logic [2:0]      placed_col;
  logic            rejected;
  logic [5:0]      move_count;
  logic            board_full;

  piece_drop_engine dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .move_valid  (move_valid),
    .move_col    (move_col),
    .move_player (move_player),
    .move_ready  (move_ready),
    .board       (board),
    .col_full    (col_full),
    .done        (done),
    .placed_row  (placed_row),
    .placed_col  (placed_col),
    .rejected    (rejected),
    .move_count  (move_count),
    .board_full  (board_full)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // reference model of the board
  logic [1:0] mb [0:5][0:6];
  int         h [0:6];
  int         mcount;
  logic [2:0] mprow;
  logic [2:0] mpcol;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_board(input string name);
    int found;
    int fr;
    int fc;
    found = 0;
    fr = 0;
    fc = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        if (found == 0 && board[r][c] !== mb[r][c]) begin
          found = 1;
          fr = r;
          fc = c;
        end
    total++;
    if (found != 0) begin
      bad++;
      $display("FAIL %s: cell[%0d][%0d] got=%0h expected=%0h", name, fr, fc,
               board[fr][fc], mb[fr][fc]);
    end
  endtask

  task automatic model_reset_board();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        mb[r][c] = 2'b00;
    for (int c = 0; c < 7; c++) h[c] = 0;
    mcount = 0;
  endtask

  // Apply one accepted move to the model and push the expected event.
  task automatic model_push(input logic [2:0] col, input logic [1:0] pl, input int e0);
    int row;
    int ecyc;
    logic is_done;
    is_done = 1'b0;
    if (col > 3'd6 || !(pl == 2'b01 || pl == 2'b10)) begin
      ecyc = e0;
    end else if (h[col] >= 6) begin
      ecyc = e0 + 6;
    end else begin
      row = 5 - h[col];
      h[col]++;
      mb[row][col] = pl;
      mcount++;
      mprow = 3'(row);
      mpcol = col;
      is_done = 1'b1;
      ecyc = e0 + (6 - row);
    end
    exp_q.push_back({is_done, ~is_done, mprow, mpcol, 6'(mcount), 16'(ecyc)});
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!move_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!move_ready) chk("ready_timeout", 64'(move_ready), 64'd1);
  endtask

  // Issue one move at a negedge; returns at a negedge with the engine idle again.
  task automatic drive_move(input logic [2:0] col, input logic [1:0] pl);
    int e0;
    wait_ready();
    move_valid  = 1'b1;
    move_col    = col;
    move_player = pl;
    @(posedge clk);
    #1;
    e0 = cyc;
    move_valid = 1'b0;
    model_push(col, pl, e0);
    @(negedge clk);
    wait_ready();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    chk("ready_during_clear", 64'(move_ready), 64'd0);
    @(negedge clk);
    clear = 1'b0;
    model_reset_board();
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && (done || rejected)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: done=%0b rejected=%0b row=%0d col=%0d cyc=%0d",
                 done, rejected, placed_row, placed_col, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event{done,rej,row,col,count,cyc}",
            64'({done, rejected, placed_row, placed_col, move_count, 16'(cyc)}), 64'(e));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  int hold_vals [0:2];

  initial begin
    int k;
    int e0;
    hold_vals[0] = 5;
    hold_vals[1] = 6;
    hold_vals[2] = 0;
    rst = 1'b1;
    clear = 1'b0;
    move_valid = 1'b0;
    move_col = '0;
    move_player = '0;
    model_reset_board();
    mprow = '0;
    mpcol = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_move_count", 64'(move_count), 64'd0);
    chk("rst_placed", 64'({placed_row, placed_col}), 64'd0);
    chk("rst_done_rej", 64'({done, rejected}), 64'd0);
    chk("rst_ready", 64'(move_ready), 64'd1);
    chk("rst_col_full", 64'(col_full), 64'd0);
    chk("rst_board_full", 64'(board_full), 64'd0);
    chk_board("rst_board");

    // single move into empty column 3
    drive_move(3'd3, 2'b01);
    chk("first_cell_5_3", 64'(board[5][3]), 64'd1);
    chk("first_count", 64'(move_count), 64'd1);
    chk_board("first_board");

    // new game; placed_row/col survive clear
    do_clear();
    chk("clear_placed_hold", 64'({placed_row, placed_col}), 64'({3'd5, 3'd3}));
    chk("clear_count", 64'(move_count), 64'd0);
    chk_board("clear_board");

    // six alternating moves into col 0, then a 7th rejected
    for (int i = 0; i < 6; i++) drive_move(3'd0, (i % 2 == 0) ? 2'b01 : 2'b10);
    for (int r = 0; r < 6; r++)
      chk("col0_stack", 64'(board[r][0]), ((5 - r) % 2 == 0) ? 64'd1 : 64'd2);
    chk("col0_full", 64'(col_full), 64'h01);
    drive_move(3'd0, 2'b01);
    chk("col0_count", 64'(move_count), 64'd6);
    chk_board("col0_board");

    // illegal inputs
    drive_move(3'd7, 2'b01);
    drive_move(3'd2, 2'b11);
    drive_move(3'd2, 2'b00);
    chk("illegal_count", 64'(move_count), 64'd6);
    chk_board("illegal_board");

    // clear aborts an in-flight scan into a 3-high column
    do_clear();
    drive_move(3'd2, 2'b01);
    drive_move(3'd2, 2'b10);
    drive_move(3'd2, 2'b01);
    move_valid = 1'b1;
    move_col = 3'd2;
    move_player = 2'b10;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    #1;
    chk("abort_ready_low", 64'(move_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b0;
    model_reset_board();
    @(negedge clk);
    chk("abort_ready_back", 64'(move_ready), 64'd1);
    chk("abort_count", 64'(move_count), 64'd0);
    chk_board("abort_board");

    // move_valid held while move_col wanders during the scan
    drive_move(3'd1, 2'b01);
    drive_move(3'd1, 2'b10);
    move_valid = 1'b1;
    move_col = 3'd1;
    move_player = 2'b01;
    @(posedge clk);
    #1;
    e0 = cyc;
    model_push(3'd1, 2'b01, e0);
    k = 0;
    @(negedge clk);
    while (!done && k < 10) begin
      move_col = 3'(hold_vals[k % 3]);
      k++;
      @(negedge clk);
    end
    move_valid = 1'b0;
    chk("hold_done_seen", 64'(done), 64'd1);
    @(negedge clk);
    wait_ready();
    chk("hold_cell_3_1", 64'(board[3][1]), 64'd1);
    chk_board("hold_board");

    // fill the whole board
    do_clear();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        drive_move(3'(c), (r % 2 == 0) ? 2'b01 : 2'b10);
    chk("full_board_full", 64'(board_full), 64'd1);
    chk("full_count", 64'(move_count), 64'd42);
    chk("full_col_full", 64'(col_full), 64'h7F);
    chk_board("full_board");
    drive_move(3'd3, 2'b01);
    drive_move(3'd6, 2'b10);
    chk("full_count_after", 64'(move_count), 64'd42);
    chk_board("full_board_after");

    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
